// File: rtl/adder_decoder.sv
// -----------------------------------------------------------------------------
// adder_decoder
//
// Receive-side inverse of the gated adder. Takes the 5-bit gated sum c and the
// b operand that produced it, and recovers the original 4-bit a operand.
//
// The adder computes:
//   sum = 2a+b for a in {1,2,3}, else a+b
//   c   = sum  for b in {3,5},   else 0
//
// Each result is classified as OK, AMBIG, GATED or ERROR. Results are queued
// in a small in-order FIFO with a valid/ready output. Two saturating counters
// track ERROR and AMBIG results.
//
// Datapath: input register (S1) -> decode -> FIFO -> output.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous reset, active low
//   in_valid   - {in_c, in_b} valid
//   in_ready   - an input can be accepted this cycle (registered state only)
//   in_c       - gated sum to decode
//   in_b       - b operand that produced in_c
//   out_valid  - FIFO head valid
//   out_ready  - consumer takes the head this cycle
//   out_a      - decoded a (primary candidate), 0 while out_valid is low
//   out_alt    - alternate a candidate, nonzero only for AMBIG
//   out_status - 0 OK, 1 AMBIG, 2 GATED, 3 ERROR
//   clr_cnt    - synchronous clear of both counters (wins over increment)
//   err_cnt    - saturating count of ERROR results
//   ambig_cnt  - saturating count of AMBIG results
// -----------------------------------------------------------------------------
module adder_decoder #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_c,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_a,
    output logic [3:0] out_alt,
    output logic [1:0] out_status,
    input  logic       clr_cnt,
    output logic [7:0] err_cnt,
    output logic [7:0] ambig_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_AMBIG = 2'd1;
    localparam logic [1:0] ST_GATED = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic          s1_valid_q, s1_valid_d;
    logic [4:0]    s1_c_q,     s1_c_d;
    logic [3:0]    s1_b_q,     s1_b_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic [7:0]    err_cnt_q,  err_cnt_d;
    logic [7:0]    ambig_cnt_q, ambig_cnt_d;

    // FIFO storage: entry = {a, alt, status}
    logic [9:0]    mem [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [AW+1:0] occupancy;
    logic [9:0]    head;

    // ---------------------------------------------------------------------
    // Decode of the S1 entry
    // ---------------------------------------------------------------------
    logic [5:0] diff;
    logic [3:0] diff_lo;
    logic       in_range;
    logic       b_pass;
    logic       u_valid;
    logic       s_valid;
    logic [3:0] dec_a;
    logic [3:0] dec_alt;
    logic [1:0] dec_status;

    // Two's-complement difference: bit 5 set means negative, bit 4 set on a
    // non-negative value means > 15.
    assign diff     = {1'b0, s1_c_q} - {2'b00, s1_b_q};
    assign diff_lo  = diff[3:0];
    assign in_range = (diff[5:4] == 2'b00);
    assign b_pass   = (s1_b_q == 4'd3) || (s1_b_q == 4'd5);

    // Unscaled candidate cannot be 1..3 (those a values are always doubled);
    // scaled candidate must be an even diff whose half lands in 1..3.
    assign u_valid = in_range && !(diff_lo inside {4'd1, 4'd2, 4'd3});
    assign s_valid = in_range && !diff_lo[0] &&
                     (diff_lo[3:1] inside {3'd1, 3'd2, 3'd3});

    always_comb begin
        dec_a      = 4'd0;
        dec_alt    = 4'd0;
        dec_status = ST_ERROR;
        if (!b_pass) begin
            dec_status = (s1_c_q == 5'd0) ? ST_GATED : ST_ERROR;
        end else if (u_valid && s_valid) begin
            dec_status = ST_AMBIG;
            dec_a      = diff_lo;
            dec_alt    = {1'b0, diff_lo[3:1]};
        end else if (u_valid) begin
            dec_status = ST_OK;
            dec_a      = diff_lo;
        end else if (s_valid) begin
            dec_status = ST_OK;
            dec_a      = {1'b0, diff_lo[3:1]};
        end
    end

    // ---------------------------------------------------------------------
    // Flow control
    // ---------------------------------------------------------------------
    // Counting the S1 slot as occupied reserves FIFO space for it, so the
    // unconditional push from S1 can never overflow.
    assign occupancy = {1'b0, count_q} + (AW+2)'(s1_valid_q);
    assign in_ready  = (occupancy < DEPTH_W);
    assign accept    = in_valid && in_ready;
    assign push      = s1_valid_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        s1_valid_d  = accept;
        s1_c_d      = s1_c_q;
        s1_b_d      = s1_b_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_cnt_d   = err_cnt_q;
        ambig_cnt_d = ambig_cnt_q;

        if (accept) begin
            s1_c_d = in_c;
            s1_b_d = in_b;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (clr_cnt) begin
            err_cnt_d   = 8'd0;
            ambig_cnt_d = 8'd0;
        end else if (push) begin
            if (dec_status == ST_ERROR && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (dec_status == ST_AMBIG && ambig_cnt_q != 8'hFF) begin
                ambig_cnt_d = ambig_cnt_q + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_c_q      <= 5'd0;
            s1_b_q      <= 4'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_cnt_q   <= 8'd0;
            ambig_cnt_q <= 8'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_c_q      <= s1_c_d;
            s1_b_q      <= s1_b_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_cnt_q   <= err_cnt_d;
            ambig_cnt_q <= ambig_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {dec_a, dec_alt, dec_status};
        end
    end

    // ---------------------------------------------------------------------
    // Outputs (payload forced to zero while nothing is valid)
    // ---------------------------------------------------------------------
    assign head       = mem[rd_ptr_q];
    assign out_a      = out_valid ? head[9:6] : 4'd0;
    assign out_alt    = out_valid ? head[5:2] : 4'd0;
    assign out_status = out_valid ? head[1:0] : 2'd0;
    assign err_cnt    = err_cnt_q;
    assign ambig_cnt  = ambig_cnt_q;

endmodule

// File: tb/tb_adder_decoder.sv
// -----------------------------------------------------------------------------
// tb_adder_decoder
//
// Directed bench for adder_decoder. Every accepted input pushes its expected
// {a, alt, status} into a queue; each output handshake pops and compares.
// Expected values come from a brute-force forward model of the gated adder.
// -----------------------------------------------------------------------------
module tb_adder_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_c;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a;
    logic [3:0] out_alt;
    logic [1:0] out_status;
    logic       clr_cnt;
    logic [7:0] err_cnt;
    logic [7:0] ambig_cnt;

    int         total = 0;
    int         bad   = 0;
    int         txn   = 0;
    logic [9:0] exp_q [$];
    logic [9:0] exp_head;

    adder_decoder #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_c       (in_c),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_alt    (out_alt),
        .out_status (out_status),
        .clr_cnt    (clr_cnt),
        .err_cnt    (err_cnt),
        .ambig_cnt  (ambig_cnt)
    );

    always #5 clk = ~clk;

    // Forward model: try every a, run the gated adder, collect matches.
    function automatic logic [9:0] model(input logic [4:0] c, input logic [3:0] b);
        int         nu;
        int         ns;
        int         sum;
        logic [3:0] ua;
        logic [3:0] sa;
        nu = 0;
        ns = 0;
        ua = 4'd0;
        sa = 4'd0;
        if (b != 4'd3 && b != 4'd5) begin
            return (c == 5'd0) ? {4'd0, 4'd0, 2'd2} : {4'd0, 4'd0, 2'd3};
        end
        for (int a = 0; a < 16; a++) begin
            sum = (a >= 1 && a <= 3) ? (2 * a + int'(b)) : (a + int'(b));
            if (sum == int'(c)) begin
                if (a >= 1 && a <= 3) begin
                    ns++;
                    sa = 4'(a);
                end else begin
                    nu++;
                    ua = 4'(a);
                end
            end
        end
        if (nu > 0 && ns > 0) return {ua, sa, 2'd1};
        if (nu > 0)           return {ua, 4'd0, 2'd0};
        if (ns > 0)           return {sa, 4'd0, 2'd0};
        return {4'd0, 4'd0, 2'd3};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
    task automatic send(input logic [4:0] c, input logic [3:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_c     = c;
        in_b     = b;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid !== 1'b0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Scoreboard: compare on handshake, enqueue on accept.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", exp_q.size(), 1);
            end else begin
                exp_head = exp_q.pop_front();
                txn++;
                $display("txn %0d: a=%0d alt=%0d status=%0d expect a=%0d alt=%0d status=%0d",
                         txn, out_a, out_alt, out_status,
                         exp_head[9:6], exp_head[5:2], exp_head[1:0]);
                chk("txn", {out_a, out_alt, out_status}, exp_head);
            end
        end else if (out_valid === 1'b0) begin
            chk("gate", {out_a, out_alt, out_status}, 0);
        end
        if (rst === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
            exp_q.push_back(model(in_c, in_b));
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_c      = 5'd0;
        in_b      = 4'd0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ambig_cnt", ambig_cnt, 0);
        sync();

        // Latency: S1 after accept edge, visible one edge later
        send(5'd8, 4'd3);
        @(negedge clk);
        chk("lat_s1", out_valid, 0);
        @(negedge clk);
        chk("lat_out", out_valid, 1);
        sync();

        // OK and AMBIG decodes
        send(5'd7, 4'd5);
        send(5'd9, 4'd5);
        send(5'd9, 4'd3);
        drain();
        chk("ambig_cnt_2", ambig_cnt, 2);
        chk("err_cnt_0", err_cnt, 0);

        // Gated and error cases
        send(5'd0, 4'd4);
        send(5'd7, 4'd4);
        send(5'd4, 4'd3);
        send(5'd2, 4'd5);
        drain();
        chk("err_cnt_3", err_cnt, 3);
        chk("ambig_cnt_hold", ambig_cnt, 2);

        // Backpressure: 6 offered, 4 accepted while stalled
        out_ready = 1'b0;
        send(5'd8, 4'd3);
        send(5'd7, 4'd5);
        send(5'd9, 4'd5);
        send(5'd9, 4'd3);
        in_valid = 1'b1;
        in_c     = 5'd10;
        in_b     = 4'd5;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        chk("bp_accepted", exp_q.size(), 4);
        out_ready = 1'b1;
        send(5'd10, 4'd5);
        send(5'd3, 4'd3);
        drain();

        // Full with S1 valid: push and pop on the same edge
        out_ready = 1'b0;
        send(5'd16, 4'd5);
        send(5'd6, 4'd3);
        send(5'd9, 4'd5);
        send(5'd0, 4'd2);
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        sync();
        out_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_in_ready", in_ready, 1);
        chk("pushpop_out_valid", out_valid, 1);
        out_ready = 1'b1;
        sync();
        drain();

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            send(5'd7, 4'd4);
        end
        drain();
        chk("err_sat", err_cnt, 255);
        send(5'd2, 4'd3);
        drain();
        chk("err_sat_hold", err_cnt, 255);

        // Clear wins over a same-edge increment
        send(5'd7, 4'd4);
        clr_cnt = 1'b1;
        sync();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_err", err_cnt, 0);
        chk("clr_ambig", ambig_cnt, 0);
        sync();
        send(5'd9, 4'd5);
        drain();
        chk("post_clr_ambig", ambig_cnt, 1);
        chk("post_clr_err", err_cnt, 0);

        // Reset with entries queued
        out_ready = 1'b0;
        send(5'd8, 4'd3);
        send(5'd7, 4'd4);
        send(5'd9, 4'd3);
        sync();
        sync();
        @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_err", err_cnt, 1);
        chk("pre_rst_ambig", ambig_cnt, 2);
        sync();
        rst = 1'b0;
        exp_q.delete();
        sync();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_ambig", ambig_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_empty", out_valid, 0);
        end
        sync();
        send(5'd8, 4'd3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
